// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit_if
//  Description : Bundles the instruction-memory port, the redirect request and
//                the decoupled instruction output of the fetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface instruction_fetch_unit_if;
    logic [31:0] inst_add;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_fault;

    // Fetch unit side
    modport master (
        output inst_add,
        input  inst_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output misalign_fault
    );

    // Core / memory side
    modport slave (
        input  inst_add,
        output inst_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  misalign_fault
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Sequential instruction fetcher with a small prefetch FIFO of
//                {pc, inst} pairs, redirect flush and misaligned-target fault.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    instruction_fetch_unit_if.master    bus
);

    localparam int              c_PW      = $clog2(QDEPTH);
    localparam logic [c_PW:0]   c_DEPTH   = (c_PW+1)'(QDEPTH);
    localparam logic [c_PW:0]   c_CNT_ONE = (c_PW+1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_fpc;
    logic [c_PW:0]     r_count;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [31:0]       r_pc_mem   [QDEPTH];
    logic [31:0]       r_inst_mem [QDEPTH];

    logic              w_out_valid;
    logic              w_pop;
    logic              w_push;

    // Handshake qualifiers; a full queue still accepts a word when the head leaves
    always_comb begin
        w_out_valid = (r_count != '0) && (r_state == ST_RUN);
        w_pop       = w_out_valid && bus.out_ready;
        w_push      = (r_state == ST_RUN) && !bus.redirect_valid &&
                      ((r_count < c_DEPTH) || w_pop);
    end

    assign bus.inst_add       = r_fpc;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_inst       = r_inst_mem[r_rd_ptr];
    assign bus.out_pc         = r_pc_mem[r_rd_ptr];
    assign bus.misalign_fault = (r_state == ST_FAULT);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only a redirect moves the FSM, its target alignment decides where
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = (bus.redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
        end
    end

    // Fetch PC, occupancy and pointers; redirect flushes and discards any pop
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fpc    <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_fpc    <= {bus.redirect_pc[31:2], 2'b00};
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Queue storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clock) begin
        if (reset && w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fpc;
            r_inst_mem[r_wr_ptr] <= bus.inst_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Bench for instruction_fetch_unit. Two instances (default
//                parameters, and RESET_PC near the top of memory with a deeper
//                queue) share one stimulus stream and are each compared every
//                cycle against a queue-level model of the fetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit_if bus0 ();
    instruction_fetch_unit_if bus1 ();

    // Memory content: word i holds 0x1000_0000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign bus0.inst_data      = mem_word(bus0.inst_add);
    assign bus1.inst_data      = mem_word(bus1.inst_add);
    assign bus0.redirect_valid = redirect_valid;
    assign bus1.redirect_valid = redirect_valid;
    assign bus0.redirect_pc    = redirect_pc;
    assign bus1.redirect_pc    = redirect_pc;
    assign bus0.out_ready      = out_ready;
    assign bus1.out_ready      = out_ready;

    instruction_fetch_unit dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.master)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (4)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] c_rst   [2];
    int          c_depth [2];
    logic [31:0] m_fpc   [2];
    int          m_cnt   [2];
    logic [31:0] m_qpc   [2][8];
    logic [31:0] m_qin   [2][8];
    bit          m_fault [2];
    bit          m_init  [2];

    initial begin
        c_rst[0] = 32'h0000_0000; c_depth[0] = 2;
        c_rst[1] = 32'hFFFF_FFF8; c_depth[1] = 4;
        m_init[0] = 1'b0; m_init[1] = 1'b0;
    end

    // Model update: queue of fetched words, head at index 0
    always @(posedge clock) begin
        bit vld, pop, push;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_fpc[i]   = c_rst[i];
                m_cnt[i]   = 0;
                m_fault[i] = 1'b0;
                m_init[i]  = 1'b1;
            end else if (m_init[i]) begin
                if (redirect_valid) begin
                    m_cnt[i]   = 0;
                    m_fpc[i]   = {redirect_pc[31:2], 2'b00};
                    m_fault[i] = (redirect_pc[1:0] != 2'b00);
                end else begin
                    vld  = (m_cnt[i] != 0) && !m_fault[i];
                    pop  = vld && out_ready;
                    push = !m_fault[i] && ((m_cnt[i] < c_depth[i]) || pop);
                    if (pop) begin
                        for (int k = 0; k < 7; k++) begin
                            m_qpc[i][k] = m_qpc[i][k+1];
                            m_qin[i][k] = m_qin[i][k+1];
                        end
                        m_cnt[i]--;
                    end
                    if (push) begin
                        m_qpc[i][m_cnt[i]] = m_fpc[i];
                        m_qin[i][m_cnt[i]] = mem_word(m_fpc[i]);
                        m_cnt[i]++;
                        m_fpc[i] = m_fpc[i] + 32'd4;
                    end
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clock) begin
        bit ev;
        for (int i = 0; i < 2; i++) begin
            if (m_init[i]) begin
                ev = (m_cnt[i] != 0) && !m_fault[i];
                if (i == 0) begin
                    chk("m0.out_valid", {31'd0, bus0.out_valid}, {31'd0, ev});
                    chk("m0.inst_add", bus0.inst_add, m_fpc[0]);
                    chk("m0.misalign", {31'd0, bus0.misalign_fault}, {31'd0, m_fault[0]});
                    if (ev) begin
                        chk("m0.out_pc", bus0.out_pc, m_qpc[0][0]);
                        chk("m0.out_inst", bus0.out_inst, m_qin[0][0]);
                    end
                end else begin
                    chk("m1.out_valid", {31'd0, bus1.out_valid}, {31'd0, ev});
                    chk("m1.inst_add", bus1.inst_add, m_fpc[1]);
                    chk("m1.misalign", {31'd0, bus1.misalign_fault}, {31'd0, m_fault[1]});
                    if (ev) begin
                        chk("m1.out_pc", bus1.out_pc, m_qpc[1][0]);
                        chk("m1.out_inst", bus1.out_inst, m_qin[1][0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (2) step();

        // Release with out_ready=1: one word per cycle from the cycle after release
        reset = 1'b1;
        step();
        chk("rel.valid0", {31'd0, bus0.out_valid}, 32'd1);
        chk("rel.pc0", bus0.out_pc, 32'h0000_0000);
        chk("rel.inst0", bus0.out_inst, 32'h1000_0000);
        chk("rel.pc1", bus1.out_pc, 32'hFFFF_FFF8);
        step();
        chk("seq.pc0", bus0.out_pc, 32'h0000_0004);
        chk("seq.inst0", bus0.out_inst, 32'h1000_0001);
        chk("seq.pc1", bus1.out_pc, 32'hFFFF_FFFC);
        step();
        chk("seq2.pc0", bus0.out_pc, 32'h0000_0008);
        chk("wrap.pc1", bus1.out_pc, 32'h0000_0000);
        chk("wrap.inst1", bus1.out_inst, 32'h1000_0000);

        // Build two entries, then reset mid-operation
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rst.valid0", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst.fault0", {31'd0, bus0.misalign_fault}, 32'd0);
        chk("rst.add0", bus0.inst_add, 32'h0000_0000);
        chk("rst.add1", bus1.inst_add, 32'hFFFF_FFF8);

        // Stall after release: queue saturates, fetch address stops
        reset = 1'b1;
        repeat (5) step();
        chk("stall.add0", bus0.inst_add, 32'h0000_0008);
        chk("stall.pc0", bus0.out_pc, 32'h0000_0000);
        chk("stall.valid0", {31'd0, bus0.out_valid}, 32'd1);
        chk("stall.add1", bus1.inst_add, 32'h0000_0008);
        chk("stall.pc1", bus1.out_pc, 32'hFFFF_FFF8);
        out_ready = 1'b1;
        step();
        chk("resume.pc0", bus0.out_pc, 32'h0000_0004);
        step();
        chk("resume2.pc0", bus0.out_pc, 32'h0000_0008);
        chk("resume2.pc1", bus1.out_pc, 32'h0000_0000);

        // Redirect with a full queue
        out_ready = 1'b0;
        repeat (2) step();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("redir.valid0", {31'd0, bus0.out_valid}, 32'd0);
        step();
        chk("redir.pc0", bus0.out_pc, 32'h0000_0100);
        chk("redir.inst0", bus0.out_inst, 32'h1000_0040);
        step();
        chk("redir2.pc0", bus0.out_pc, 32'h0000_0104);

        // Misaligned redirect, then recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis.fault0", {31'd0, bus0.misalign_fault}, 32'd1);
        chk("mis.valid0", {31'd0, bus0.out_valid}, 32'd0);
        chk("mis.add0", bus0.inst_add, 32'h0000_0100);
        repeat (3) step();
        chk("mis.hold0", bus0.inst_add, 32'h0000_0100);
        chk("mis.hfault0", {31'd0, bus0.misalign_fault}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("fix.fault0", {31'd0, bus0.misalign_fault}, 32'd0);
        chk("fix.valid0", {31'd0, bus0.out_valid}, 32'd0);
        step();
        chk("fix.pc0", bus0.out_pc, 32'h0000_0200);
        chk("fix.inst0", bus0.out_inst, 32'h1000_0080);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 99) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom();
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) redirect_pc[31:8] = 24'hFFFFFF;
            step();
        end

        reset          = 1'b1;
        redirect_valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
